// File: rtl/soc_gpio_edge_pio_if.sv
// Register bus for soc_gpio_edge_pio.
//   address    : register select (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (bits above the port width are ignored by the slave)
//   readdata   : registered read data, valid one clock after address is presented
interface soc_gpio_edge_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/soc_gpio_edge_pio.sv
// General-purpose I/O port with synchronised inputs and per-bit edge capture interrupt.
//   clk      : system clock, all state changes on its rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : register bus (slave side)
//              0 data (read sync input / write data_out), 1 direction, 2 irqmask,
//              3 edgecapture (write-1-to-clear), 4 outset, 5 outclear, 6-7 reserved
//   in_port  : asynchronous external inputs
//   out_port : output data register
//   oe_port  : direction register, 1 = drive
//   irq      : level interrupt, OR of edgecapture & irqmask
module soc_gpio_edge_pio #(
   parameter int unsigned           DATA_WIDTH  = 10,
   parameter int unsigned           SYNC_STAGES = 2,
   parameter int unsigned           EDGE_TYPE   = 0,
   parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   soc_gpio_edge_pio_if.slave    bus,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic [DATA_WIDTH-1:0] oe_port,
   output logic                  irq
);

   localparam logic [2:0] AddrData = 3'd0;
   localparam logic [2:0] AddrDir  = 3'd1;
   localparam logic [2:0] AddrMask = 3'd2;
   localparam logic [2:0] AddrEdge = 3'd3;
   localparam logic [2:0] AddrSet  = 3'd4;
   localparam logic [2:0] AddrClr  = 3'd5;

   localparam int unsigned     CntW    = 3;
   localparam logic [CntW-1:0] SupLoad = CntW'(SYNC_STAGES + 1);

   logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] sync_in;
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] dir_q, dir_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] ec_q, ec_d;
   logic [DATA_WIDTH-1:0] clr;
   logic [DATA_WIDTH-1:0] edge_raw;
   logic [DATA_WIDTH-1:0] wdata;
   logic [31:0]           rd_q, rd_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  wr_en;

   assign wr_en   = bus.chipselect & ~bus.write_n;
   assign wdata   = bus.writedata[DATA_WIDTH-1:0];
   assign sync_in = sync_q[SYNC_STAGES-1];

   if (DATA_WIDTH < 32) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = ^bus.writedata[31:DATA_WIDTH];
   end

   // Input synchroniser chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_comb begin
      dout_d = dout_q;
      dir_d  = dir_q;
      mask_d = mask_q;
      clr    = '0;
      if (wr_en) begin
         case (bus.address)
            AddrData: dout_d = wdata;
            AddrDir:  dir_d  = wdata;
            AddrMask: mask_d = wdata;
            AddrEdge: clr    = wdata;
            AddrSet:  dout_d = dout_q | wdata;
            AddrClr:  dout_d = dout_q & ~wdata;
            default:  ;
         endcase
      end

      if (EDGE_TYPE == 0) begin
         edge_raw = sync_in & ~prev_q;
      end else if (EDGE_TYPE == 1) begin
         edge_raw = ~sync_in & prev_q;
      end else begin
         edge_raw = sync_in ^ prev_q;
      end

      // Edges are ignored until the reset-state pipeline has flushed; a new edge
      // overrides a same-cycle clear.
      ec_d = ec_q & ~clr;
      if (cnt_q == '0) ec_d = ec_d | edge_raw;

      cnt_d = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;

      case (bus.address)
         AddrData: rd_d = 32'(sync_in);
         AddrDir:  rd_d = 32'(dir_q);
         AddrMask: rd_d = 32'(mask_q);
         AddrEdge: rd_d = 32'(ec_q);
         default:  rd_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q <= OUT_RESET;
         dir_q  <= '0;
         mask_q <= '0;
         ec_q   <= '0;
         prev_q <= '0;
         rd_q   <= '0;
         cnt_q  <= SupLoad;
      end else begin
         dout_q <= dout_d;
         dir_q  <= dir_d;
         mask_q <= mask_d;
         ec_q   <= ec_d;
         prev_q <= sync_in;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.readdata = rd_q;
   assign out_port     = dout_q;
   assign oe_port      = dir_q;
   assign irq          = |(ec_q & mask_q);

endmodule

// File: tb/tb_soc_gpio_edge_pio.sv
module tb_soc_gpio_edge_pio;
   localparam int S = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   soc_gpio_edge_pio_if bus1();
   soc_gpio_edge_pio_if bus2();

   logic [9:0] in1, in2, out1, oe1, out2, oe2;
   logic       irq1, irq2;

   soc_gpio_edge_pio #(
      .DATA_WIDTH(10), .SYNC_STAGES(2), .EDGE_TYPE(0), .OUT_RESET(10'h000)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(bus1),
      .in_port(in1), .out_port(out1), .oe_port(oe1), .irq(irq1)
   );

   soc_gpio_edge_pio #(
      .DATA_WIDTH(10), .SYNC_STAGES(2), .EDGE_TYPE(2), .OUT_RESET(10'h2A5)
   ) u_dut_any (
      .clk(clk), .reset_n(reset_n), .bus(bus2),
      .in_port(in2), .out_port(out2), .oe_port(oe2), .irq(irq2)
   );

   // Reference model of u_dut: register contents plus the history of sampled inputs.
   logic [9:0]  m_dout, m_dir, m_mask, m_ec;
   logic [31:0] m_rd;
   logic [9:0]  hist[$];
   int          n_vec, n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_dout = 10'h000;
      m_dir  = '0;
      m_mask = '0;
      m_ec   = '0;
      m_rd   = '0;
      hist.delete();
   endtask

   function automatic logic [9:0] sample_at(input int idx);
      return (idx >= 0) ? hist[idx] : 10'h000;
   endfunction

   task automatic drive(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
      bus1.chipselect = cs;
      bus1.write_n    = wn;
      bus1.address    = a;
      bus1.writedata  = d;
   endtask

   // One clock: predict from present inputs, clock, then compare every output of u_dut.
   task automatic tick();
      logic [9:0]  wd, nd, ndir, nmask, nec, clr, new_v, old_v, edges;
      logic [31:0] nrd;
      int          k;
      wd = bus1.writedata[9:0];
      nd = m_dout; ndir = m_dir; nmask = m_mask; clr = '0;
      if (bus1.chipselect && !bus1.write_n) begin
         case (bus1.address)
            3'd0: nd = wd;
            3'd1: ndir = wd;
            3'd2: nmask = wd;
            3'd3: clr = wd;
            3'd4: nd = m_dout | wd;
            3'd5: nd = m_dout & ~wd;
            default: ;
         endcase
      end
      // A change in the input becomes visible S+1 clocks later; samples taken while
      // the pipeline was still flushing after reset never count as edges.
      hist.push_back(in1);
      k     = hist.size();
      new_v = sample_at(k - S - 1);
      old_v = sample_at(k - S - 2);
      edges = (k >= S + 2) ? (new_v & ~old_v) : 10'h000;
      nec   = (m_ec & ~clr) | edges;
      case (bus1.address)
         3'd0: nrd = {22'b0, new_v};
         3'd1: nrd = {22'b0, m_dir};
         3'd2: nrd = {22'b0, m_mask};
         3'd3: nrd = {22'b0, m_ec};
         default: nrd = '0;
      endcase
      @(posedge clk);
      #1;
      m_dout = nd; m_dir = ndir; m_mask = nmask; m_ec = nec; m_rd = nrd;
      check("out_port", {22'b0, out1}, {22'b0, m_dout});
      check("oe_port", {22'b0, oe1}, {22'b0, m_dir});
      check("irq", {31'b0, irq1}, {31'b0, |(m_ec & m_mask)});
      check("readdata", bus1.readdata, m_rd);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      drive(1'b0, 1'b1, 3'd0, 32'h0);
      bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.address = 3'd0; bus2.writedata = '0;
      in1 = 10'h3FF;
      in2 = 10'h000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_readdata", bus1.readdata, 32'h0);
      check("rst_out", {22'b0, out1}, 32'h0);
      check("rst_oe", {22'b0, oe1}, 32'h0);
      check("rst_irq", {31'b0, irq1}, 32'h0);
      check("rst_out_any", {22'b0, out2}, 32'h2A5);
      reset_n = 1'b1;

      // Input already high through reset release: nothing may be captured.
      drive(1'b0, 1'b1, 3'd3, 32'h0);
      repeat (20) begin
         tick();
         check("hold_ec", bus1.readdata, 32'h0);
         check("hold_irq", {31'b0, irq1}, 32'h0);
      end

      // Output register load / clear / set and direction width truncation.
      drive(1'b1, 1'b0, 3'd0, 32'h3FF); tick(); check("out_load", {22'b0, out1}, 32'h3FF);
      drive(1'b1, 1'b0, 3'd5, 32'h00F); tick(); check("out_clr", {22'b0, out1}, 32'h3F0);
      drive(1'b1, 1'b0, 3'd4, 32'h100); tick(); check("out_set", {22'b0, out1}, 32'h3F0);
      drive(1'b1, 1'b0, 3'd1, 32'hFFFFF); tick(); check("oe_trunc", {22'b0, oe1}, 32'h3FF);

      // Falling edges are ignored by the rising-edge instance.
      in1 = 10'h000;
      drive(1'b0, 1'b1, 3'd3, 32'h0);
      repeat (6) tick();
      check("fall_ignored", bus1.readdata, 32'h0);

      // Single rising edge on bit0 with the mask set.
      drive(1'b1, 1'b0, 3'd2, 32'h1); tick();
      drive(1'b0, 1'b1, 3'd3, 32'h0);
      in1 = 10'h001;
      tick(); tick();
      check("irq_early", {31'b0, irq1}, 32'h0);
      tick();
      check("irq_at3", {31'b0, irq1}, 32'h1);
      tick();
      check("read_ec", bus1.readdata, 32'h1);
      drive(1'b1, 1'b0, 3'd3, 32'h1); tick();
      check("irq_cleared", {31'b0, irq1}, 32'h0);

      // Edge arriving in the same cycle as a clear wins.
      drive(1'b0, 1'b1, 3'd3, 32'h0);
      in1 = 10'h000;
      repeat (4) tick();
      in1 = 10'h001;
      tick(); tick();
      drive(1'b1, 1'b0, 3'd3, 32'h1); tick();
      check("set_wins_irq", {31'b0, irq1}, 32'h1);
      drive(1'b0, 1'b1, 3'd3, 32'h0); tick();
      check("set_wins_rd", bus1.readdata, 32'h1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               $urandom);
         if ($urandom_range(0, 3) == 0) in1 = 10'($urandom);
         tick();
      end

      // Fill edgecapture, then reset in the middle of a write.
      drive(1'b1, 1'b0, 3'd2, 32'h3FF);
      in1 = 10'h000;
      tick();
      drive(1'b0, 1'b1, 3'd3, 32'h0);
      repeat (4) tick();
      in1 = 10'h3FF;
      repeat (5) tick();
      check("ec_full", bus1.readdata, 32'h3FF);
      drive(1'b1, 1'b0, 3'd0, 32'h155);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_rd", bus1.readdata, 32'h0);
      check("mid_rst_oe", {22'b0, oe1}, 32'h0);
      check("mid_rst_irq", {31'b0, irq1}, 32'h0);
      check("mid_rst_out", {22'b0, out1}, 32'h0);
      check("mid_rst_out_any", {22'b0, out2}, 32'h2A5);
      model_reset();
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 3'd0, 32'h0);
      reset_n = 1'b1;

      // Reserved addresses read zero and ignore writes.
      drive(1'b1, 1'b0, 3'd1, 32'h2AA); tick();
      drive(1'b1, 1'b0, 3'd6, 32'h3FF); tick();
      check("rd_addr6", bus1.readdata, 32'h0);
      drive(1'b1, 1'b0, 3'd7, 32'h3FF); tick();
      check("rd_addr7", bus1.readdata, 32'h0);
      check("wr_reserved", {22'b0, oe1}, 32'h2AA);

      // Any-edge instance: a one-clock pulse on bit3 is captured, irq stays masked.
      drive(1'b0, 1'b1, 3'd0, 32'h0);
      repeat (4) tick();
      in2 = 10'h008; tick();
      in2 = 10'h000; tick();
      repeat (4) tick();
      bus2.address = 3'd3;
      tick();
      check("any_ec", bus2.readdata, 32'h8);
      check("any_irq", {31'b0, irq2}, 32'h0);
      bus2.chipselect = 1'b1; bus2.write_n = 1'b0; bus2.address = 3'd5; bus2.writedata = 32'h005;
      tick();
      check("any_out_clr", {22'b0, out2}, 32'h2A0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/soc_gpio_edge_pio.md
SOC_GPIO_EDGE_PIO -- requirements
Module: soc_gpio_edge_pio

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 10, giving the port width (legal values 1..32).
REQ-002 The block SHALL take parameter SYNC_STAGES, default 2, giving the input synchroniser depth (legal values 2..4).
REQ-003 The block SHALL take parameter EDGE_TYPE, default 0, selecting the capture edge: 0 rising, 1 falling, 2 any.
REQ-004 The block SHALL take parameter OUT_RESET, default 0, giving the data_out reset value (DATA_WIDTH bits).
REQ-005 The block SHALL provide port clk, input, 1 bit, the system clock; all state changes on its rising edge.
REQ-006 The block SHALL provide port reset_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 The block SHALL provide port address, input, 3 bits, the register select.
REQ-008 The block SHALL provide port chipselect, input, 1 bit, the slave select.
REQ-009 The block SHALL provide port write_n, input, 1 bit, the active-low write strobe.
REQ-010 The block SHALL provide port writedata, input, 32 bits, the write data; bits at and above DATA_WIDTH are ignored.
REQ-011 The block SHALL provide port in_port, input, DATA_WIDTH bits, the asynchronous external inputs.
REQ-012 The block SHALL provide port readdata, output, 32 bits, the registered read data.
REQ-013 The block SHALL provide port out_port, output, DATA_WIDTH bits, the output data register.
REQ-014 The block SHALL provide port oe_port, output, DATA_WIDTH bits, the direction register (1 = drive).
REQ-015 The block SHALL provide port irq, output, 1 bit, the level interrupt.

Function
REQ-016 Register map SHALL be: 0 data (read sync input / write data_out); 1 direction; 2 irqmask; 3 edgecapture; 4 outset; 5 outclear; 6-7 reserved.
REQ-017 A write SHALL occur when chipselect=1 and write_n=0, taking effect on that clock edge.
REQ-018 Writes to addresses 0, 1 and 2 SHALL load data_out, direction and irqmask respectively; a write to 4 SHALL OR writedata into data_out; a write to 5 SHALL AND-NOT writedata into data_out.
REQ-019 Writes to addresses 6 and 7 SHALL have no effect.
REQ-020 in_port SHALL pass through a SYNC_STAGES flop chain, giving sync_in, followed by one prev_in register.
REQ-021 An edge SHALL be per bit: rising sync_in & ~prev_in; falling ~sync_in & prev_in; any sync_in ^ prev_in.
REQ-022 A detected edge SHALL set its edgecapture bit on the next clock edge, SYNC_STAGES+1 clocks after in_port changes.
REQ-023 A write to address 3 SHALL clear each edgecapture bit whose writedata bit is 1 (write-1-to-clear).
REQ-024 An edge and a clear on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-025 After reset release, a counter SHALL suppress edge detection for SYNC_STAGES+1 clocks, so no edge is captured from the reset-state pipeline.
REQ-026 irq SHALL equal OR(edgecapture & irqmask), driven from registers, with no extra delay.
REQ-027 readdata SHALL register every clock, regardless of chipselect, with zero-extended data: address 0 sync_in, 1 direction, 2 irqmask, 3 edgecapture, 4-7 zero.
REQ-028 Read latency SHALL be 1 clock, and reads SHALL have no side effects.
REQ-029 out_port SHALL equal data_out and oe_port SHALL equal direction, both directly from registers.

Reset
REQ-030 Asserting reset_n low SHALL immediately clear readdata, direction, irqmask, edgecapture, the sync chain, prev_in and irq to 0, and set data_out to OUT_RESET, including mid-operation.
REQ-031 On reset_n release, the suppression counter SHALL restart from SYNC_STAGES+1.

Verification (DATA_WIDTH=10, SYNC_STAGES=2, EDGE_TYPE=0 unless stated)
REQ-032 Write 0x3FF to addr 0, then 0x00F to addr 5, then 0x100 to addr 4 -> out_port sequence 0x3FF, 0x3F0, 0x3F0; a write of 0xFFFFF to addr 1 -> oe_port 0x3FF.
REQ-033 in_port held at 0x3FF through reset release -> edgecapture stays 0 and irq stays 0 for 20 clocks.
REQ-034 irqmask=0x001, then in_port bit0 0->1 -> edgecapture 0x001 after 3 clocks, irq=1; reading addr 3 returns 0x001 one clock later; write 0x001 to addr 3 -> irq=0 next cycle.
REQ-035 A new bit0 rising edge arrives in the same cycle as a write-1-clear of bit0 -> edgecapture bit0 remains 1.
REQ-036 EDGE_TYPE=2 with in_port bit3 pulsing 0->1->0 -> edgecapture bit3 set; irqmask=0 -> irq stays 0 while edgecapture reads 0x008.
REQ-037 Assert reset_n mid-write with edgecapture=0x3FF -> all outputs 0 and out_port=OUT_RESET asynchronously; readdata from addr 6 and addr 7 = 0.
